// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared widths, opcode and A-source encodings for the accumulator datapath
package ec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

endpackage

// File: rtl/ec_ram.sv
// rtl/ec_ram.sv - single-port synchronous-read, read-first RAM with a priority program-load port
module ec_ram
  import ec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Read and write share an edge, so the read naturally returns the pre-write word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[addr_i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (prog_we_i) begin
        mem_q[prog_addr_i] <= prog_data_i;
      end else if (wr_en_i) begin
        mem_q[addr_i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ec_datapath.sv
// rtl/ec_datapath.sv - PC, IR, accumulator and add/sub ALU around ec_ram
// Optional signed-overflow flag output ovf enabled by EC_OVF_FLAG_EN.
module ec_datapath
  import ec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Asel,
  input  logic [DATA_W-1:0] Input,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OP_W-1:0]   IR,
  output logic              Aeq0,
  output logic              Apos,
`ifdef EC_OVF_FLAG_EN
  output logic              ovf,
`endif
  output logic [DATA_W-1:0] Aout,
  output logic [ADDR_W-1:0] PCout
);

  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, rd_data, alu_res;

  ec_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock_i     (clock),
    .reset_i     (reset),
    .addr_i      (mem_addr),
    .wr_en_i     (MemWr),
    .wr_data_i   (a_q),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data),
    .rd_data_o   (rd_data)
  );

  always_comb begin
    mem_addr = Meminst ? ir_q[ADDR_W-1:0] : pc_q;
    alu_res  = Sub ? (a_q - rd_data) : (a_q + rd_data);

    pc_d = pc_q;
    if (PCload) begin
      pc_d = JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end

    ir_d = IRload ? rd_data : ir_q;

    a_d = a_q;
    if (Aload) begin
      case (Asel)
        ASEL_ALU: a_d = alu_res;
        ASEL_IN:  a_d = Input;
        ASEL_MEM: a_d = rd_data;
        default:  a_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
    end
  end

`ifdef EC_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Add overflows on like-signed operands, subtract on unlike-signed; both flip the sign of A.
  always_comb begin
    ovf_d = ovf_q;
    if (Aload) begin
      ovf_d = (Asel == ASEL_ALU)
           && (Sub ? (a_q[DATA_W-1] != rd_data[DATA_W-1])
                   : (a_q[DATA_W-1] == rd_data[DATA_W-1]))
           && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign IR    = ir_q[DATA_W-1 -: OP_W];
  assign Aeq0  = (a_q == '0);
  assign Apos  = !a_q[DATA_W-1] && (a_q != '0);
  assign Aout  = a_q;
  assign PCout = pc_q;

endmodule

// File: tb/tb_ec_datapath.sv
// tb/tb_ec_datapath.sv - scoreboard bench for ec_datapath against a behavioural model (EC_OVF_FLAG_EN aware)
module tb_ec_datapath;

  typedef struct packed {
    logic       rst, irl, jmp, pcl, mi, mw, al, sb;
    logic [1:0] as;
    logic [7:0] inp;
    logic       pw;
    logic [4:0] pa;
    logic [7:0] pd;
  } ctrl_t;

  typedef struct {
    int         step;
    logic [4:0] pc;
    logic [7:0] a;
    logic [2:0] ir;
    logic       aeq0, apos, ovf;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, prog_we;
  logic [1:0] Asel;
  logic [7:0] Input, prog_data, Aout;
  logic [4:0] prog_addr, PCout;
  logic [2:0] IR;
  logic       Aeq0, Apos;
`ifdef EC_OVF_FLAG_EN
  logic       ovf;
`endif

  ec_datapath dut (
    .clock(clock), .reset(reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel),
    .Input(Input), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
`ifdef EC_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .Aout(Aout), .PCout(PCout)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  int   nstep = 0;
  exp_t sb_q[$];

  // Reference state, advanced once per clock from the architectural rules.
  logic [7:0] m_mem [32];
  logic [4:0] m_pc  = '0;
  logic [7:0] m_ir  = '0;
  logic [7:0] m_a   = '0;
  logic [7:0] m_rd  = '0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int st);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, st, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("PCout", 32'(PCout), 32'(e.pc), e.step);
      chk("Aout", 32'(Aout), 32'(e.a), e.step);
      chk("IR", 32'(IR), 32'(e.ir), e.step);
      chk("Aeq0", 32'(Aeq0), 32'(e.aeq0), e.step);
      chk("Apos", 32'(Apos), 32'(e.apos), e.step);
`ifdef EC_OVF_FLAG_EN
      chk("ovf", 32'(ovf), 32'(e.ovf), e.step);
`endif
    end
  end

  task automatic model(input ctrl_t c);
    int addr, ua, ur, sa, sr, s;
    logic [7:0] old_rd, old_a;
    addr = c.mi ? int'(m_ir[4:0]) : int'(m_pc);
    if (c.rst) begin
      m_pc = '0; m_ir = '0; m_a = '0; m_rd = '0; m_ovf = 1'b0;
    end else begin
      old_rd = m_rd;
      old_a  = m_a;
      m_rd   = m_mem[addr];
      if (c.pw) m_mem[c.pa] = c.pd;
      else if (c.mw) m_mem[addr] = old_a;
      if (c.pcl) m_pc = c.jmp ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
      if (c.irl) m_ir = old_rd;
      if (c.al) begin
        ua = int'(old_a);
        ur = int'(old_rd);
        sa = (ua >= 128) ? ua - 256 : ua;
        sr = (ur >= 128) ? ur - 256 : ur;
        case (c.as)
          2'd0: begin
            s     = c.sb ? sa - sr : sa + sr;
            m_a   = 8'((s + 512) % 256);
            m_ovf = (s > 127) || (s < -128);
          end
          2'd1: begin m_a = c.inp; m_ovf = 1'b0; end
          2'd2: begin m_a = old_rd; m_ovf = 1'b0; end
          default: begin m_a = 8'd0; m_ovf = 1'b0; end
        endcase
      end
    end
  endtask

  task automatic step(input ctrl_t c);
    exp_t e;
    reset = c.rst; IRload = c.irl; JMPmux = c.jmp; PCload = c.pcl; Meminst = c.mi;
    MemWr = c.mw; Aload = c.al; Sub = c.sb; Asel = c.as; Input = c.inp;
    prog_we = c.pw; prog_addr = c.pa; prog_data = c.pd;
    @(posedge clock);
    model(c);
    nstep++;
    e.step = nstep; e.pc = m_pc; e.a = m_a; e.ir = m_ir[7:5];
    e.aeq0 = (m_a == 8'd0); e.apos = (m_a >= 8'd1) && (m_a <= 8'd127); e.ovf = m_ovf;
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input logic mi);
    ctrl_t c = '0;
    c.mi = mi;
    step(c);
  endtask

  task automatic prog(input int ad, input int d);
    ctrl_t c = '0;
    c.pw = 1'b1; c.pa = 5'(ad); c.pd = 8'(d);
    step(c);
  endtask

  task automatic seta(input int v);
    ctrl_t c = '0;
    c.al = 1'b1; c.as = 2'd1; c.inp = 8'(v);
    step(c);
  endtask

  task automatic alu(input logic sb);
    ctrl_t c = '0;
    c.mi = 1'b1; c.al = 1'b1; c.as = 2'd0; c.sb = sb;
    step(c);
  endtask

  task automatic setir(input int w);
    ctrl_t c = '0;
    prog(int'(m_pc), w);
    idle(1'b0);
    c.irl = 1'b1;
    step(c);
  endtask

  initial begin
    ctrl_t c;
    reset = 1'b1; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Aload = 0; Sub = 0; Asel = 2'd0; Input = '0; prog_we = 0; prog_addr = '0; prog_data = '0;
    @(negedge clock);
    c = '0; c.rst = 1'b1;
    step(c);
    for (int i = 0; i < 32; i++) prog(i, $urandom_range(0, 255));

    // Reset with arbitrary enables, including write strobes that must be ignored.
    for (int i = 0; i < 2; i++) begin
      c = ctrl_t'($urandom);
      c.rst = 1'b1; c.mw = 1'b1; c.pw = i[0];
      step(c);
    end

    // Walk PC through all words (covers 31 -> 0 wrap) loading A from each.
    for (int i = 0; i < 32; i++) begin
      idle(1'b0);
      c = '0; c.al = 1'b1; c.as = 2'd2; c.pcl = 1'b1;
      step(c);
    end

    // Fetch
    prog(0, 8'h45);
    idle(1'b0);
    c = '0; c.irl = 1'b1; c.pcl = 1'b1;
    step(c);

    // Add/sub wrap through IR address 5
    prog(5, 8'h03);
    seta(8'hFE);
    idle(1'b1);
    alu(1'b0);
    alu(1'b1);
    seta(8'h7F);
    alu(1'b0);
    alu(1'b1);
    seta(8'h80);
    alu(1'b1);

    // Store read-first at address 9, then program-load priority
    seta(8'h5A);
    setir(8'h29);
    c = '0; c.mi = 1'b1; c.mw = 1'b1;
    step(c);
    c = '0; c.mi = 1'b1; c.al = 1'b1; c.as = 2'd2;
    step(c);
    step(c);
    c = '0; c.mi = 1'b1; c.mw = 1'b1; c.pw = 1'b1; c.pa = 5'd9; c.pd = 8'h33;
    step(c);
    c = '0; c.mi = 1'b1; c.al = 1'b1; c.as = 2'd2;
    step(c);
    step(c);

    // Jumps
    setir(8'hB4);
    c = '0; c.pcl = 1'b1; c.jmp = 1'b1;
    step(c);
    setir(8'h1F);
    c = '0; c.pcl = 1'b1; c.jmp = 1'b1;
    step(c);
    c = '0; c.pcl = 1'b1;
    step(c);

    // Input and flags
    seta(8'h80);
    c = '0; c.al = 1'b1; c.as = 2'd3;
    step(c);
    seta(8'h01);

    // Randomized control mix
    for (int i = 0; i < 600; i++) begin
      c = ctrl_t'($urandom);
      c.rst = ($urandom_range(0, 39) == 0);
      c.pw  = ($urandom_range(0, 7) == 0);
      step(c);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
